// File: rtl/ir_queue.sv
`default_nettype none
// ============================================================================
// Module      : ir_queue
// Description : DEPTH-entry in-order instruction buffer between fetch and
//               decode. Carries a PC tag with each instruction, handles
//               valid/ready stalls and flushes with NOP insertion. The head
//               entry is presented from output registers.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_queue #(
  parameter int               WIDTH    = 32,
  parameter int               PC_WIDTH = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP      = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [WIDTH-1:0]           i_in_instr,
  input  logic [PC_WIDTH-1:0]        i_in_pc,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [WIDTH-1:0]           o_out_instr,
  output logic [PC_WIDTH-1:0]        o_out_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

  // Circular storage; slot r_rd_ptr always mirrors the head registers
  logic [WIDTH-1:0]    r_mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] r_mem_pc    [DEPTH];

  logic [c_PW-1:0]     r_wr_ptr;
  logic [c_PW-1:0]     r_rd_ptr;
  logic [c_CW-1:0]     r_count;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_instr;
  logic [PC_WIDTH-1:0] r_out_pc;

  logic                w_kill;
  logic                w_push;
  logic                w_pop;
  logic [c_PW-1:0]     w_rd_next;

  // Ready depends only on the registered count, so out_ready never reaches it
  assign o_in_ready = (r_count < c_FULL);

  // Reset and flush both discard the contents and suppress any transfer
  always_comb begin
    w_kill    = rst | i_flush;
    w_push    = i_in_valid & o_in_ready & ~w_kill;
    w_pop     = r_out_valid & i_out_ready & ~w_kill;
    w_rd_next = r_rd_ptr + c_PTR_ONE;
  end

  // Storage write; no reset needed since validity is tracked by the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= i_in_instr;
      r_mem_pc[r_wr_ptr]    <= i_in_pc;
    end
  end

  // Pointers, occupancy and registered head entry
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= NOP;
      r_out_pc    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= w_rd_next;

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        // With two or more entries the successor is already in storage and
        // cannot be the slot being written this cycle
        if (r_count > c_CNT_ONE) begin
          r_out_instr <= r_mem_instr[w_rd_next];
          r_out_pc    <= r_mem_pc[w_rd_next];
        end else if (w_push) begin
          r_out_instr <= i_in_instr;
          r_out_pc    <= i_in_pc;
        end else begin
          r_out_valid <= 1'b0;
          r_out_instr <= NOP;
          r_out_pc    <= '0;
        end
      end else if (w_push && (r_count == '0)) begin
        r_out_valid <= 1'b1;
        r_out_instr <= i_in_instr;
        r_out_pc    <= i_in_pc;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_instr = r_out_instr;
  assign o_out_pc    = r_out_pc;
  assign o_count     = r_count;

endmodule
`default_nettype wire
